// File: rtl/pq_arbiter.sv
// pq_arbiter
//   Shares a single priority-queue device among N_CLIENTS requesters. Each
//   client may ask for an enqueue, a dequeue, or a replace (enqueue plus
//   dequeue). A round-robin arbiter picks one eligible request at a time,
//   drives the single-cycle enq/deq strobes into the queue, waits out the
//   queue's busy signal, and returns dequeued key-value pairs tagged with the
//   owning client's ID.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_enq/req_deq per-client request bits, held by the client until gnt
//   req_kv          per-client enqueue data, client i at [i*KV_W +: KV_W]
//   gnt             one-hot, one-cycle grant pulse
//   rsp_vld         one-cycle pulse: rsp_id/rsp_kv carry a dequeued item
//   rsp_id, rsp_kv  owner and value of the dequeued item
//   pq_enq, pq_deq  queue strobes, high only in the ISSUE cycle
//   pq_kvi          queue input data (holds its last value when idle)
//   pq_kvo          queue head (minimum), valid when !pq_empty
//   pq_full, pq_empty, pq_busy   queue status
module pq_arbiter #(
  parameter int  N_CLIENTS = 4,
  parameter int  KEY_W     = 16,
  parameter int  VAL_W     = 16,
  localparam int KV_W      = KEY_W + VAL_W,
  localparam int ID_W      = $clog2(N_CLIENTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CLIENTS-1:0]      req_enq,
  input  logic [N_CLIENTS-1:0]      req_deq,
  input  logic [N_CLIENTS*KV_W-1:0] req_kv,
  output logic [N_CLIENTS-1:0]      gnt,
  output logic                      rsp_vld,
  output logic [ID_W-1:0]           rsp_id,
  output logic [KV_W-1:0]           rsp_kv,
  output logic                      pq_enq,
  output logic                      pq_deq,
  output logic [KV_W-1:0]           pq_kvi,
  input  logic [KV_W-1:0]           pq_kvo,
  input  logic                      pq_full,
  input  logic                      pq_empty,
  input  logic                      pq_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [ID_W:0]   N_EXT   = (ID_W+1)'(N_CLIENTS);
  localparam logic [ID_W-1:0] LAST_ID = (ID_W)'(N_CLIENTS - 1);

  state_t                 state_q,   state_d;
  logic [ID_W-1:0]        ptr_q,     ptr_d;
  logic [ID_W-1:0]        win_id_q,  win_id_d;
  logic                   win_deq_q, win_deq_d;
  logic [N_CLIENTS-1:0]   gnt_q,     gnt_d;
  logic                   rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0]        rsp_id_q,  rsp_id_d;
  logic [KV_W-1:0]        rsp_kv_q,  rsp_kv_d;
  logic                   pq_enq_q,  pq_enq_d;
  logic                   pq_deq_q,  pq_deq_d;
  logic [KV_W-1:0]        pq_kvi_q,  pq_kvi_d;

  // Per-client eligibility and unpacked view of the request data.
  // Any request containing a dequeue needs a non-empty queue; a replace is
  // allowed on a full queue because it removes one item as it adds one.
  logic [N_CLIENTS-1:0] elig;
  logic [KV_W-1:0]      kv_arr [N_CLIENTS];

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
    assign kv_arr[gi] = req_kv[gi*KV_W +: KV_W];
    assign elig[gi]   = req_deq[gi] ? ~pq_empty : (req_enq[gi] & ~pq_full);
  end

  // Round-robin scan: first eligible index at or above the pointer, wrapping.
  logic [ID_W:0]   scan_idx;
  logic            pick_vld;
  logic [ID_W-1:0] pick_id;

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    scan_idx = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= N_EXT) begin
        scan_idx = scan_idx - N_EXT;
      end
      if (!pick_vld && elig[scan_idx[ID_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = scan_idx[ID_W-1:0];
      end
    end
  end

  logic start;
  assign start = (state_q == IDLE) && !pq_busy && pick_vld;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_id_q  <= '0;
      win_deq_q <= 1'b0;
      gnt_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_kv_q  <= '0;
      pq_enq_q  <= 1'b0;
      pq_deq_q  <= 1'b0;
      pq_kvi_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_id_q  <= win_id_d;
      win_deq_q <= win_deq_d;
      gnt_q     <= gnt_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_kv_q  <= rsp_kv_d;
      pq_enq_q  <= pq_enq_d;
      pq_deq_q  <= pq_deq_d;
      pq_kvi_q  <= pq_kvi_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (!pq_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. Strobes, grant and rsp_vld are single-cycle
  // pulses, so they default low; data registers hold.
  always_comb begin
    win_id_d  = win_id_q;
    win_deq_d = win_deq_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    pq_enq_d  = 1'b0;
    pq_deq_d  = 1'b0;
    pq_kvi_d  = pq_kvi_q;
    rsp_vld_d = 1'b0;
    rsp_id_d  = rsp_id_q;
    rsp_kv_d  = rsp_kv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          win_id_d       = pick_id;
          win_deq_d      = req_deq[pick_id];
          pq_kvi_d       = kv_arr[pick_id];
          pq_enq_d       = req_enq[pick_id];
          pq_deq_d       = req_deq[pick_id];
          gnt_d[pick_id] = 1'b1;
        end
      end
      ISSUE: begin
        // The head seen while the deq strobe is high is the item removed;
        // for a replace it is the old head, not the newly inserted item.
        if (win_deq_q) begin
          rsp_vld_d = 1'b1;
          rsp_id_d  = win_id_q;
          rsp_kv_d  = pq_kvo;
        end
        ptr_d = (win_id_q == LAST_ID) ? '0 : win_id_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt     = gnt_q;
  assign rsp_vld = rsp_vld_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_kv  = rsp_kv_q;
  assign pq_enq  = pq_enq_q;
  assign pq_deq  = pq_deq_q;
  assign pq_kvi  = pq_kvi_q;

endmodule

// File: doc/pq_arbiter.md
Name: pq_arbiter

Overview:
- Shares one priority-queue device among N_CLIENTS requesters.
- Each client issues enqueue, dequeue or replace (enqueue plus dequeue) requests.
- Round-robin arbitration selects one request at a time. The block sequences the single-cycle enq/deq strobes into the queue and waits out the queue's busy signal.
- Dequeued key-value pairs are returned to the winning client, tagged with its ID.
- Sits between client logic and any PQ implementation: heap, systolic or shift-register.

Parameters:
- N_CLIENTS, 4, number of requesters (2..16).
- KEY_W, 16, key width in bits.
- VAL_W, 16, value width in bits.
- KV_W, KEY_W+VAL_W, packed key-value width {key,value}; derived, not overridden.
- ID_W, clog2(N_CLIENTS), client index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_enq  in  N_CLIENTS  per-client enqueue request; held until granted
- req_deq  in  N_CLIENTS  per-client dequeue request; held until granted
- req_kv  in  N_CLIENTS*KV_W  per-client enqueue data; client i occupies bits [i*KV_W +: KV_W]
- gnt  out  N_CLIENTS  one-hot grant pulse, 1 cycle
- rsp_vld  out  1  dequeued data valid pulse
- rsp_id  out  ID_W  client that owns rsp_kv
- rsp_kv  out  KV_W  dequeued key-value pair
- pq_enq  out  1  queue enqueue strobe
- pq_deq  out  1  queue dequeue strobe
- pq_kvi  out  KV_W  queue input data
- pq_kvo  in  KV_W  queue head (minimum) item, valid when !pq_empty
- pq_full  in  1  queue full
- pq_empty  in  1  queue empty
- pq_busy  in  1  queue still processing previous operation

Behaviour:
- Reset (rst=1 at a clk edge), synchronous, clears all registers:
  - gnt=0, rsp_vld=0, rsp_id=0, rsp_kv=0.
  - pq_enq=0, pq_deq=0, pq_kvi=0.
  - RR pointer=0, state=IDLE.
  - Reset mid-operation abandons the operation. No grant or response is produced for it, and strobes are low from the next cycle. Queue consistency is the system's responsibility, since the queue shares rst.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - A client is eligible as follows:
    - enq-only: eligible if !pq_full.
    - deq-only: eligible if !pq_empty.
    - enq&deq (replace): eligible if !pq_empty, even when full.
    - Ineligible requests are skipped, not dropped.
  - If pq_busy=0 and any client is eligible: pick the first eligible index starting at the RR pointer, searching upward with wrap. Register winner ID, op bits and kv, set pq_kvi, set pq_enq/pq_deq per the op, set gnt[winner], and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - pq_enq/pq_deq/gnt are high for this cycle only.
  - If op includes deq, capture pq_kvo into rsp_kv and rsp_id=winner. rsp_vld pulses high on the following cycle.
  - RR pointer = (winner+1) mod N_CLIENTS.
  - Go to WAIT.
- WAIT:
  - Strobes low. Stay while pq_busy=1; go to IDLE when pq_busy=0.
  - With a zero-latency queue WAIT lasts 1 cycle, giving a minimum of 3 cycles per operation.
- Client rule: the client drops its request the cycle after gnt. The arbiter does not re-grant the same client before returning to IDLE.
- Replace: rsp_kv returns the old head; the new item is inserted by the queue.
- At most one strobe pair per operation; pq_enq/pq_deq are never high outside ISSUE.
- pq_kvi holds its last value when idle.

Test Plan:
- Reset, then client 0 enq kv=0x0005_00AA with pq_busy=0 -> gnt=0001 exactly 1 cycle, with pq_enq=1 and pq_kvi=0x000500AA in the same cycle. No rsp_vld.
- Clients 0..3 all request enq simultaneously, queue never full -> grants in order 0,1,2,3, each 3 cycles apart. A second round starting with pointer=0 again follows order 0,1,2,3.
- pq_empty=1 with client 2 requesting deq and client 3 requesting enq -> client 3 granted; client 2 is held until pq_empty=0, then granted. rsp_id=2 and rsp_kv equal pq_kvo from the ISSUE cycle, with rsp_vld one cycle after gnt.
- pq_full=1 with client 1 requesting enq&deq kv=0x0001_0001 and head=0x0003_0007 -> granted with pq_enq=pq_deq=1, rsp_kv=0x00030007 and rsp_id=1.
- pq_busy held high for 5 cycles after ISSUE -> no new grant until busy falls. The next gnt comes 2 cycles after busy deasserts.
- rst asserted during WAIT with requests pending -> the next cycle shows all outputs 0, state IDLE, pointer 0. The first grant after reset goes to the lowest eligible index.
